paint_scheduler: RTL and testbench

Frame scan controller for the paint pipeline. It generates the `paint_x`/`paint_y` coordinate stream that feeds the layer renderers (background, pipes, bird). It tracks every coordinate in flight through the fixed-latency, non-stallable renderer pipeline and captures the returned `paint_color` into a credit-protected FIFO. It presents the pixels to the LCD writer over a valid/ready stream and signals frame boundaries.

---
 rtl/paint_pkg.sv | 19 +
 rtl/sync_fifo.sv | 61 ++++++
 rtl/paint_scheduler.sv | 158 +++++++++++++++
 tb/tb_paint_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/paint_pkg.sv
// Shared definitions for the paint pipeline: scan FSM states, bus widths
// and default screen geometry used by the scheduler, renderers and LCD writer.
package paint_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned COLOR_W = 16;
  localparam int unsigned COORD_W = 16;

  localparam int unsigned DEF_X_SIZE     = 480;
  localparam int unsigned DEF_Y_SIZE     = 800;
  localparam int unsigned DEF_PIPE_LAT   = 5;
  localparam int unsigned DEF_FIFO_DEPTH = 16;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous single-clock FIFO with occupancy count.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset (pointers/count)
//   wr_en_i/wr_data_i push side (ignored when full)
//   rd_en_i/rd_data_o pop side; rd_data_o is the current head (show-ahead)
//   empty_o, full_o   status flags
//   count_o           number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;
  logic             do_wr;
  logic             do_rd;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rptr_q];
  assign count_o   = count_q;

  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (do_rd) begin
        rptr_q <= rptr_q + AW'(1);
      end
      count_q <= count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

endmodule

// File: rtl/paint_scheduler.sv
// Frame scan controller: issues (paint_x, paint_y) coordinates to the
// fixed-latency renderer pipeline, captures the returned colors into a
// credit-protected FIFO and streams them to the LCD writer.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   frame_start                 start a frame (only honoured in IDLE)
//   busy, frame_done            frame in progress / one-cycle end pulse
//   paint_x, paint_y, paint_valid  coordinate issue to the renderers
//   paint_color                 renderer result, PIPE_LAT cycles after issue
//   out_color, out_valid, out_last, out_ready  pixel stream to LCD writer
module paint_scheduler
  import paint_pkg::*;
#(
  parameter int unsigned X_SIZE     = DEF_X_SIZE,
  parameter int unsigned Y_SIZE     = DEF_Y_SIZE,
  parameter int unsigned PIPE_LAT   = DEF_PIPE_LAT,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_start,
  output logic                      busy,
  output logic                      frame_done,
  output logic signed [COORD_W-1:0] paint_x,
  output logic signed [COORD_W-1:0] paint_y,
  output logic                      paint_valid,
  input  logic        [COLOR_W-1:0] paint_color,
  output logic        [COLOR_W-1:0] out_color,
  output logic                      out_valid,
  output logic                      out_last,
  input  logic                      out_ready
);

  localparam int unsigned XW    = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int unsigned YW    = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

  state_e               state_q;
  logic                 busy_q;
  logic                 done_q;
  logic [XW-1:0]        x_q;
  logic [YW-1:0]        y_q;
  logic [PIPE_LAT-1:0]  vpipe_q;
  logic [PIPE_LAT-1:0]  lpipe_q;

  logic [CNT_W-1:0]     inflight;
  logic [CNT_W-1:0]     fifo_count;
  logic [CNT_W:0]       outstanding;
  logic                 issue;
  logic                 last_coord;
  logic                 pop;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [COLOR_W:0]     fifo_head;

  assign last_coord = (x_q == X_LAST) && (y_q == Y_LAST);

  // Credit is FIFO occupancy plus everything still in the renderer; a pop in
  // this cycle only frees a slot once it is reflected in fifo_count.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < PIPE_LAT; i++) begin
      inflight = inflight + CNT_W'(vpipe_q[i]);
    end
    outstanding = {1'b0, fifo_count} + {1'b0, inflight};
    issue       = (state_q == SCAN) && (outstanding < (CNT_W+1)'(FIFO_DEPTH));
  end

  assign pop = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (frame_start) begin
            state_q <= SCAN;
            busy_q  <= 1'b1;
            x_q     <= '0;
            y_q     <= '0;
          end
        end
        SCAN: begin
          if (issue) begin
            if (last_coord) begin
              state_q <= DRAIN;
            end else if (x_q == X_LAST) begin
              x_q <= '0;
              y_q <= y_q + YW'(1);
            end else begin
              x_q <= x_q + XW'(1);
            end
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Valid and last flags travel alongside each coordinate through the renderer.
  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe_q <= '0;
      lpipe_q <= '0;
    end else begin
      vpipe_q[0] <= issue;
      lpipe_q[0] <= issue && last_coord;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        vpipe_q[i] <= vpipe_q[i-1];
        lpipe_q[i] <= lpipe_q[i-1];
      end
    end
  end

  sync_fifo #(
    .WIDTH (COLOR_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (vpipe_q[PIPE_LAT-1]),
    .wr_data_i ({lpipe_q[PIPE_LAT-1], paint_color}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_head),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .count_o   (fifo_count)
  );

  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign paint_valid = issue;
  assign paint_x     = COORD_W'(x_q);
  assign paint_y     = COORD_W'(y_q);
  assign out_valid   = !fifo_empty;
  assign out_color   = out_valid ? fifo_head[COLOR_W-1:0] : '0;
  assign out_last    = out_valid && fifo_head[COLOR_W];

endmodule

// File: tb/tb_paint_scheduler.sv
module tb_paint_scheduler;

  localparam int XS  = 4;
  localparam int YS  = 3;
  localparam int LAT = 5;
  localparam int DEP = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               frame_start;
  logic               busy;
  logic               frame_done;
  logic signed [15:0] paint_x;
  logic signed [15:0] paint_y;
  logic               paint_valid;
  logic        [15:0] paint_color;
  logic        [15:0] out_color;
  logic               out_valid;
  logic               out_last;
  logic               out_ready;

  paint_scheduler #(
    .X_SIZE     (XS),
    .Y_SIZE     (YS),
    .PIPE_LAT   (LAT),
    .FIFO_DEPTH (DEP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .busy        (busy),
    .frame_done  (frame_done),
    .paint_x     (paint_x),
    .paint_y     (paint_y),
    .paint_valid (paint_valid),
    .paint_color (paint_color),
    .out_color   (out_color),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  // Stub renderer: {y[7:0], x[7:0]} of whatever is on the bus, LAT cycles later.
  logic [15:0] rsr [LAT];
  always @(posedge clk) begin
    rsr[0] <= {paint_y[7:0], paint_x[7:0]};
    for (int i = 1; i < LAT; i++) rsr[i] <= rsr[i-1];
  end
  assign paint_color = rsr[LAT-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard queues filled by the reference model at frame start.
  logic [16:0] exp_px  [$];
  logic [31:0] exp_iss [$];

  int start_cyc, first_hs_rel, last_hs_rel, done_rel;
  int px_cnt, issue_cnt, done_cnt, outstanding;
  logic prev_last = 1'b0;
  logic rnd_mode = 1'b0;

  task automatic push_frame_model();
    for (int y = 0; y < YS; y++) begin
      for (int x = 0; x < XS; x++) begin
        logic [7:0] yb, xb;
        yb = y[7:0];
        xb = x[7:0];
        exp_px.push_back({(x == XS-1 && y == YS-1), yb, xb});
        exp_iss.push_back({x[15:0], y[15:0]});
      end
    end
  endtask

  // Monitor: compares every observed issue and pixel handshake.
  always @(negedge clk) begin
    if (rst) begin
      exp_px.delete();
      exp_iss.delete();
      outstanding = 0;
      prev_last   = 1'b0;
    end else begin
      checks++;
      if (frame_done !== prev_last) begin
        errors++;
        $display("FAIL frame_done_timing cyc=%0d got=%b exp=%b", cyc, frame_done, prev_last);
      end
      if (frame_done) begin
        done_cnt++;
        done_rel = cyc - start_cyc;
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_at_done got=%b exp=0", busy);
        end
      end
      if (paint_valid) begin
        logic [31:0] e;
        checks++;
        if (exp_iss.size() == 0) begin
          errors++;
          $display("FAIL unexpected_issue got=(%0d,%0d) exp=none", paint_x, paint_y);
        end else begin
          e = exp_iss.pop_front();
          if ({paint_x, paint_y} !== e) begin
            errors++;
            $display("FAIL issue_coord got=(%0d,%0d) exp=(%0d,%0d)", paint_x, paint_y, e[31:16], e[15:0]);
          end
        end
        outstanding++;
        issue_cnt++;
      end
      if (out_valid && out_ready) begin
        logic [16:0] e;
        checks++;
        if (exp_px.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel got=%h last=%b exp=none", out_color, out_last);
        end else begin
          e = exp_px.pop_front();
          if ({out_last, out_color} !== e) begin
            errors++;
            $display("FAIL pixel got=%h last=%b exp=%h last=%b", out_color, out_last, e[15:0], e[16]);
          end
        end
        if (px_cnt == 0) first_hs_rel = cyc - start_cyc;
        if (out_last) last_hs_rel = cyc - start_cyc;
        px_cnt++;
        outstanding--;
      end
      prev_last = out_valid && out_ready && out_last;
      checks++;
      if (outstanding > DEP || outstanding < 0) begin
        errors++;
        $display("FAIL outstanding got=%0d exp<=%0d", outstanding, DEP);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic start_frame();
    @(posedge clk);
    #1;
    frame_start  = 1'b1;
    start_cyc    = cyc;
    px_cnt       = 0;
    issue_cnt    = 0;
    first_hs_rel = -1;
    last_hs_rel  = -1;
    done_rel     = -1;
    push_frame_model();
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    check("busy_first_cycle", int'(busy), 1);
    check("first_issue_valid", int'(paint_valid), 1);
    check("first_issue_xy", int'({paint_x, paint_y}), 0);
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt != d0) break;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL frame_done_timeout waited=%0d cycles", budget);
    end
  endtask

  initial begin
    rst         = 1'b1;
    frame_start = 1'b0;
    out_ready   = 1'b1;
    done_cnt    = 0;
    px_cnt      = 0;
    issue_cnt   = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_paint_valid", int'(paint_valid), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_color", int'(out_color), 0);
    check("rst_paint_xy", int'({paint_x, paint_y}), 0);

    // Full frame with out_ready held high: exact cycle timing.
    start_frame();
    wait_done(100);
    check("full_first_pixel_cycle", first_hs_rel, 7);
    check("full_last_pixel_cycle", last_hs_rel, 18);
    check("full_done_cycle", done_rel, 19);
    check("full_pixel_count", px_cnt, XS*YS);
    check("full_queue_empty", exp_px.size(), 0);

    // Backpressure from the first cycle.
    out_ready = 1'b0;
    start_frame();
    repeat (30) @(posedge clk);
    #1;
    check("bp_issue_count", issue_cnt, DEP);
    check("bp_outstanding", outstanding, DEP);
    check("bp_paint_valid", int'(paint_valid), 0);
    check("bp_out_valid", int'(out_valid), 1);
    check("bp_head", int'(out_color), 0);
    out_ready = 1'b1;
    wait_done(100);
    check("bp_pixel_count", px_cnt, XS*YS);
    check("bp_queue_empty", exp_px.size(), 0);

    // Random backpressure over many frames.
    rnd_mode = 1'b1;
    for (int f = 0; f < 20; f++) begin
      start_frame();
      wait_done(600);
      check("rnd_pixel_count", px_cnt, XS*YS);
    end
    rnd_mode = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b1;

    // frame_start while busy must be ignored.
    begin
      int d0;
      d0 = done_cnt;
      start_frame();
      repeat (4) @(posedge clk);
      #1 frame_start = 1'b1;
      @(posedge clk);
      #1 frame_start = 1'b0;
      wait_done(100);
      repeat (30) @(posedge clk);
      check("busy_start_done_count", done_cnt - d0, 1);
      check("busy_start_pixels", px_cnt, XS*YS);
      check("busy_start_idle", int'(busy), 0);
    end

    // Reset in the middle of a frame.
    start_frame();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_paint_x", int'(paint_x), 0);
    check("midrst_paint_y", int'(paint_y), 0);
    repeat (10) @(posedge clk);
    #1;
    check("midrst_still_idle", int'(out_valid), 0);
    start_frame();
    wait_done(100);
    check("midrst_pixel_count", px_cnt, XS*YS);
    check("midrst_first_pixel_cycle", first_hs_rel, 7);
    check("midrst_queue_empty", exp_px.size(), 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
